// File: rtl/oflow_core_fsm_set_dispatch.sv
// Frame-level set dispatcher: latches the bbox count, splits it into PE-wide sets and
// sequences set loads into the PE buffers ahead of the feature-extraction FSM.
module oflow_core_fsm_set_dispatch #(
  parameter int PE_NUM  = 24,
  parameter int SET_LEN = 6,
  parameter int BBOX_W  = 11,
  parameter int FRAME_W = 16
) (
  input  logic               clk,
  input  logic               reset_N,
  input  logic               start_frame,
  input  logic [BBOX_W-1:0]  num_of_bbox_in_frame,
  input  logic               control_ready_new_set,
  input  logic               done_fe,
  input  logic               done_frame_reg,
  input  logic               load_set_done,
  output logic               load_set_req,
  output logic [SET_LEN-1:0] load_set_idx,
  output logic [BBOX_W-1:0]  load_base_addr,
  output logic [SET_LEN-1:0] num_of_sets,
  output logic [BBOX_W-1:0]  counter_of_remain_bboxes,
  output logic               start_pe,
  output logic               new_set,
  output logic [FRAME_W-1:0] frame_num,
  output logic               done_frame,
  output logic               busy,
  output logic               overflow_err
);

  localparam int                MAX_SETS = (2 ** SET_LEN) - 1;
  localparam logic [BBOX_W-1:0] MAX_N    = BBOX_W'(PE_NUM * MAX_SETS);
  localparam logic [BBOX_W-1:0] PE_STEP  = BBOX_W'(PE_NUM);
  localparam logic [BBOX_W-1:0] PE_RND   = BBOX_W'(PE_NUM - 1);

  typedef enum logic [2:0] {IDLE, CALC, LOAD, RUN, WAIT_REG} state_t;

  state_t             state_q, state_d;
  logic [BBOX_W-1:0]  n_q, n_d;
  logic [SET_LEN-1:0] idx_q, idx_d;
  logic [SET_LEN-1:0] sets_q, sets_d;
  logic [BBOX_W-1:0]  base_q, base_d;
  logic [BBOX_W-1:0]  remain_q, remain_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               req_q, req_d;
  logic               pend_q, pend_d;
  logic               start_pe_q, start_pe_d;
  logic               new_set_q, new_set_d;
  logic               done_frame_q, done_frame_d;
  logic               busy_q, busy_d;
  logic               ovf_q, ovf_d;
  logic               last_set;

  assign last_set = (idx_q == (sets_q - SET_LEN'(1)));

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    idx_d        = idx_q;
    sets_d       = sets_q;
    base_d       = base_q;
    remain_d     = remain_q;
    frame_d      = frame_q;
    pend_d       = pend_q;
    new_set_d    = new_set_q;
    busy_d       = busy_q;
    ovf_d        = ovf_q;
    req_d        = 1'b0;
    start_pe_d   = 1'b0;
    done_frame_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_frame) begin
          if (num_of_bbox_in_frame > MAX_N) begin
            n_d   = MAX_N;
            ovf_d = 1'b1;
          end else begin
            n_d = num_of_bbox_in_frame;
          end
          // an empty frame never counts as busy
          busy_d  = (n_d != '0);
          state_d = CALC;
        end
      end
      CALC: begin
        if (n_q == '0) begin
          done_frame_d = 1'b1;
          frame_d      = frame_q + FRAME_W'(1);
          state_d      = IDLE;
        end else begin
          sets_d   = SET_LEN'((n_q + PE_RND) / PE_STEP);
          remain_d = n_q;
          idx_d    = '0;
          base_d   = '0;
          req_d    = 1'b1;
          pend_d   = 1'b1;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        if (load_set_done && pend_q) begin
          pend_d     = 1'b0;
          new_set_d  = 1'b1;
          start_pe_d = 1'b1;
          state_d    = RUN;
        end
      end
      RUN: begin
        // an advance in the same cycle as a load completion drops the completion
        if (control_ready_new_set && !last_set) begin
          new_set_d = 1'b0;
          remain_d  = remain_q - PE_STEP;
          idx_d     = idx_q + SET_LEN'(1);
          base_d    = base_q + PE_STEP;
          req_d     = 1'b1;
          pend_d    = 1'b1;
        end else if (load_set_done && pend_q) begin
          pend_d    = 1'b0;
          new_set_d = 1'b1;
        end
        if (done_fe && last_set) begin
          state_d = WAIT_REG;
        end
      end
      WAIT_REG: begin
        if (done_frame_reg) begin
          done_frame_d = 1'b1;
          frame_d      = frame_q + FRAME_W'(1);
          new_set_d    = 1'b0;
          busy_d       = 1'b0;
          pend_d       = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state_q      <= IDLE;
      n_q          <= '0;
      idx_q        <= '0;
      sets_q       <= '0;
      base_q       <= '0;
      remain_q     <= '0;
      frame_q      <= '0;
      req_q        <= 1'b0;
      pend_q       <= 1'b0;
      start_pe_q   <= 1'b0;
      new_set_q    <= 1'b0;
      done_frame_q <= 1'b0;
      busy_q       <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      idx_q        <= idx_d;
      sets_q       <= sets_d;
      base_q       <= base_d;
      remain_q     <= remain_d;
      frame_q      <= frame_d;
      req_q        <= req_d;
      pend_q       <= pend_d;
      start_pe_q   <= start_pe_d;
      new_set_q    <= new_set_d;
      done_frame_q <= done_frame_d;
      busy_q       <= busy_d;
      ovf_q        <= ovf_d;
    end
  end

  assign load_set_req             = req_q;
  assign load_set_idx             = idx_q;
  assign load_base_addr           = base_q;
  assign num_of_sets              = sets_q;
  assign counter_of_remain_bboxes = remain_q;
  assign start_pe                 = start_pe_q;
  assign new_set                  = new_set_q;
  assign frame_num                = frame_q;
  assign done_frame               = done_frame_q;
  assign busy                     = busy_q;
  assign overflow_err             = ovf_q;

endmodule

// File: tb/tb_oflow_core_fsm_set_dispatch.sv
// Bench for the set dispatcher: loader model with programmable latency, FE driver,
// load-request scoreboard and per-scenario checks.
module tb_oflow_core_fsm_set_dispatch;
  localparam int PE_NUM = 24, SET_LEN = 6, BBOX_W = 11, FRAME_W = 16;

  logic clk = 1'b0, reset_N = 1'b0, start_frame = 1'b0;
  logic [BBOX_W-1:0] num_of_bbox_in_frame = '0;
  logic control_ready_new_set = 1'b0, done_fe = 1'b0, done_frame_reg = 1'b0, load_set_done = 1'b0;
  logic load_set_req, start_pe, new_set, done_frame, busy, overflow_err;
  logic [SET_LEN-1:0] load_set_idx, num_of_sets;
  logic [BBOX_W-1:0] load_base_addr, counter_of_remain_bboxes;
  logic [FRAME_W-1:0] frame_num;
  // narrow-frame-counter twin, used to see the counter wrap in a few frames
  logic s_load_set_req, s_start_pe, s_new_set, s_done_frame, s_busy, s_overflow_err;
  logic [SET_LEN-1:0] s_load_set_idx, s_num_of_sets;
  logic [BBOX_W-1:0] s_load_base_addr, s_counter;
  logic [1:0] s_frame_num;

  oflow_core_fsm_set_dispatch #(.PE_NUM(PE_NUM), .SET_LEN(SET_LEN), .BBOX_W(BBOX_W), .FRAME_W(FRAME_W)) dut (
    .clk(clk), .reset_N(reset_N), .start_frame(start_frame), .num_of_bbox_in_frame(num_of_bbox_in_frame),
    .control_ready_new_set(control_ready_new_set), .done_fe(done_fe), .done_frame_reg(done_frame_reg),
    .load_set_done(load_set_done), .load_set_req(load_set_req), .load_set_idx(load_set_idx),
    .load_base_addr(load_base_addr), .num_of_sets(num_of_sets), .counter_of_remain_bboxes(counter_of_remain_bboxes),
    .start_pe(start_pe), .new_set(new_set), .frame_num(frame_num), .done_frame(done_frame), .busy(busy),
    .overflow_err(overflow_err));

  oflow_core_fsm_set_dispatch #(.PE_NUM(PE_NUM), .SET_LEN(SET_LEN), .BBOX_W(BBOX_W), .FRAME_W(2)) dut_w2 (
    .clk(clk), .reset_N(reset_N), .start_frame(start_frame), .num_of_bbox_in_frame(num_of_bbox_in_frame),
    .control_ready_new_set(control_ready_new_set), .done_fe(done_fe), .done_frame_reg(done_frame_reg),
    .load_set_done(load_set_done), .load_set_req(s_load_set_req), .load_set_idx(s_load_set_idx),
    .load_base_addr(s_load_base_addr), .num_of_sets(s_num_of_sets), .counter_of_remain_bboxes(s_counter),
    .start_pe(s_start_pe), .new_set(s_new_set), .frame_num(s_frame_num), .done_frame(s_done_frame), .busy(s_busy),
    .overflow_err(s_overflow_err));

  always #5 clk = ~clk;

  typedef struct packed {logic [SET_LEN-1:0] idx; logic [BBOX_W-1:0] base;} load_t;

  int checks = 0, errors = 0;
  int lat = 1;
  load_t exp_q[$];
  load_t obs_q[$];
  int obs_rd = 0;
  int gaps[$];
  int rem_obs[$];
  int start_pe_cnt = 0, done_cnt = 0, busy_cnt = 0;

  // buffer loader: answers each request after 'lat' cycles, abandons it on reset
  initial begin : loader
    int cnt;
    bit alive;
    forever begin
      @(negedge clk);
      if (load_set_req === 1'b1 && reset_N === 1'b1) begin
        cnt = lat;
        alive = 1'b1;
        while (cnt > 0 && alive) begin
          @(negedge clk);
          cnt--;
          if (reset_N !== 1'b1) alive = 1'b0;
        end
        if (alive) begin
          load_set_done = 1'b1;
          @(negedge clk);
          load_set_done = 1'b0;
        end
      end
    end
  end

  // records observed load requests, pulse counts and the new_set gap after each request
  initial begin : monitor
    bit tracking;
    int zc;
    load_t o;
    tracking = 1'b0;
    zc = 0;
    forever begin
      @(negedge clk);
      if (start_pe === 1'b1) start_pe_cnt++;
      if (done_frame === 1'b1) done_cnt++;
      if (busy === 1'b1) busy_cnt++;
      if (load_set_req === 1'b1) begin
        o.idx = load_set_idx;
        o.base = load_base_addr;
        obs_q.push_back(o);
        tracking = 1'b1;
        zc = 0;
      end else if (tracking) begin
        if (new_set === 1'b1) begin
          gaps.push_back(zc);
          tracking = 1'b0;
        end else begin
          zc++;
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic send_frame(input int n);
    int nc, ns;
    load_t e;
    nc = (n > PE_NUM * 63) ? PE_NUM * 63 : n;
    ns = (nc + PE_NUM - 1) / PE_NUM;
    for (int i = 0; i < ns; i++) begin
      e.idx = SET_LEN'(i);
      e.base = BBOX_W'(i * PE_NUM);
      exp_q.push_back(e);
    end
    @(negedge clk);
    start_frame = 1'b1;
    num_of_bbox_in_frame = BBOX_W'(n);
    @(negedge clk);
    start_frame = 1'b0;
    num_of_bbox_in_frame = '0;
  endtask

  // FE side: consume each set, optionally inject a stray start_frame or a last-set advance
  task automatic run_frame(input int ns, input bit inject_sf, input bit poke_last, output bit ok);
    int t;
    ok = 1'b1;
    rem_obs.delete();
    for (int s = 0; s < ns && ok; s++) begin
      t = 0;
      while (new_set !== 1'b1 && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (new_set !== 1'b1) begin
        ok = 1'b0;
      end else begin
        rem_obs.push_back(int'(counter_of_remain_bboxes));
        if (inject_sf && s == 0) begin
          start_frame = 1'b1;
          num_of_bbox_in_frame = 11'd99;
          @(negedge clk);
          start_frame = 1'b0;
          num_of_bbox_in_frame = '0;
        end
        if (poke_last && s == ns - 1) begin
          control_ready_new_set = 1'b1;
          @(negedge clk);
          control_ready_new_set = 1'b0;
        end
        if (s < ns - 1) control_ready_new_set = 1'b1;
        else done_fe = 1'b1;
        @(negedge clk);
        control_ready_new_set = 1'b0;
        done_fe = 1'b0;
      end
    end
    if (ok) begin
      done_frame_reg = 1'b1;
      @(negedge clk);
      done_frame_reg = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({load_set_req, load_set_idx, load_base_addr, num_of_sets, counter_of_remain_bboxes, start_pe,
         new_set, frame_num, done_frame, busy, overflow_err} !== '0) begin
      errors++;
      $display("FAIL reset_hold outputs not all zero: req=%b sets=%0d remain=%0d frame=%0d busy=%b", load_set_req,
               num_of_sets, counter_of_remain_bboxes, frame_num, busy);
    end
    reset_N = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({load_set_req, start_pe, new_set, done_frame, busy, overflow_err, frame_num} !== '0) begin
      errors++;
      $display("FAIL reset_idle got req=%b start_pe=%b new_set=%b busy=%b frame=%0d expected all 0", load_set_req,
               start_pe, new_set, busy, frame_num);
    end
  endtask

  task automatic test_n50();
    int sp0, df0, n;
    bit ok;
    load_t e, o;
    sp0 = start_pe_cnt;
    df0 = done_cnt;
    send_frame(50);
    @(negedge clk);
    checks++;
    if (num_of_sets !== 6'd3 || counter_of_remain_bboxes !== 11'd50 || load_set_req !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL n50_calc sets=%0d remain=%0d req=%b busy=%b expected 3/50/1/1", num_of_sets,
               counter_of_remain_bboxes, load_set_req, busy);
    end
    run_frame(3, 1'b0, 1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL n50_timeout new_set never rose, expected 3 sets"); end
    checks++;
    if (rem_obs.size() != 3 || rem_obs[0] != 50 || rem_obs[1] != 26 || rem_obs[2] != 2) begin
      errors++;
      $display("FAIL n50_remain got %p expected 50,26,2", rem_obs);
    end
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      o = (obs_rd < obs_q.size()) ? obs_q[obs_rd] : '1;
      obs_rd++;
      checks++;
      if (o !== e) begin errors++; $display("FAIL n50_load%0d got idx=%0d base=%0d expected idx=%0d base=%0d", i, o.idx, o.base, e.idx, e.base); end
    end
    checks++;
    if (frame_num !== 16'd1 || done_cnt - df0 != 1 || start_pe_cnt - sp0 != 1 || counter_of_remain_bboxes !== 11'd2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL n50_end frame=%0d done=%0d start_pe=%0d remain=%0d busy=%b expected 1/1/1/2/0", frame_num,
               done_cnt - df0, start_pe_cnt - sp0, counter_of_remain_bboxes, busy);
    end
  endtask

  task automatic test_n24();
    int sp0, df0, n;
    bit ok;
    load_t e, o;
    sp0 = start_pe_cnt;
    df0 = done_cnt;
    send_frame(24);
    run_frame(1, 1'b0, 1'b1, ok);
    checks++;
    if (!ok || num_of_sets !== 6'd1 || rem_obs.size() != 1 || rem_obs[0] != 24) begin
      errors++;
      $display("FAIL n24_set ok=%b sets=%0d remain=%p expected 1 set with remain 24", ok, num_of_sets, rem_obs);
    end
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      o = (obs_rd < obs_q.size()) ? obs_q[obs_rd] : '1;
      obs_rd++;
      checks++;
      if (o !== e) begin errors++; $display("FAIL n24_load%0d got idx=%0d base=%0d expected idx=%0d base=%0d", i, o.idx, o.base, e.idx, e.base); end
    end
    checks++;
    if (obs_rd != obs_q.size()) begin
      errors++;
      $display("FAIL n24_extra_load got %0d requests expected %0d", obs_q.size(), obs_rd);
      obs_rd = obs_q.size();
    end
    checks++;
    if (start_pe_cnt - sp0 != 1 || done_cnt - df0 != 1 || frame_num !== 16'd2) begin
      errors++;
      $display("FAIL n24_end start_pe=%0d done=%0d frame=%0d expected 1/1/2", start_pe_cnt - sp0, done_cnt - df0, frame_num);
    end
  endtask

  task automatic test_n0();
    int sp0, df0, b0, r0;
    sp0 = start_pe_cnt;
    df0 = done_cnt;
    b0 = busy_cnt;
    r0 = obs_q.size();
    send_frame(0);
    @(negedge clk);
    checks++;
    if (done_frame !== 1'b1) begin errors++; $display("FAIL n0_done_timing got done_frame=%b expected 1 two cycles after start", done_frame); end
    repeat (4) @(negedge clk);
    checks++;
    if (start_pe_cnt != sp0 || obs_q.size() != r0 || busy_cnt != b0 || done_cnt - df0 != 1 || frame_num !== 16'd3) begin
      errors++;
      $display("FAIL n0_quiet start_pe=%0d req=%0d busy=%0d done=%0d frame=%0d expected 0/0/0/1/3", start_pe_cnt - sp0,
               obs_q.size() - r0, busy_cnt - b0, done_cnt - df0, frame_num);
    end
  endtask

  task automatic test_lat7();
    int g0, n;
    bit ok;
    load_t e, o;
    lat = 7;
    g0 = gaps.size();
    send_frame(50);
    run_frame(3, 1'b1, 1'b0, ok);
    checks++;
    if (!ok || num_of_sets !== 6'd3 || rem_obs.size() != 3 || rem_obs[0] != 50 || rem_obs[2] != 2) begin
      errors++;
      $display("FAIL lat7_ignore_start ok=%b sets=%0d remain=%p expected 3 sets 50,26,2", ok, num_of_sets, rem_obs);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (g0 + i >= gaps.size() || gaps[g0 + i] != 7) begin
        errors++;
        $display("FAIL lat7_gap%0d got %0d low cycles expected 7", i, (g0 + i < gaps.size()) ? gaps[g0 + i] : -1);
      end
    end
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      o = (obs_rd < obs_q.size()) ? obs_q[obs_rd] : '1;
      obs_rd++;
      checks++;
      if (o !== e) begin errors++; $display("FAIL lat7_load%0d got idx=%0d base=%0d expected idx=%0d base=%0d", i, o.idx, o.base, e.idx, e.base); end
    end
    checks++;
    if (frame_num !== 16'd4) begin errors++; $display("FAIL lat7_frame got %0d expected 4", frame_num); end
    lat = 1;
  endtask

  task automatic test_overflow();
    int n, bad;
    bit ok;
    load_t e, o;
    send_frame(2047);
    run_frame(63, 1'b0, 1'b0, ok);
    checks++;
    if (!ok || num_of_sets !== 6'd63 || overflow_err !== 1'b1) begin
      errors++;
      $display("FAIL ovf_clamp ok=%b sets=%0d ovf=%b expected 63 sets and ovf=1 after done", ok, num_of_sets, overflow_err);
    end
    checks++;
    if (rem_obs.size() != 63 || rem_obs[0] != 1512 || rem_obs[62] != 24) begin
      errors++;
      $display("FAIL ovf_remain size=%0d first=%0d expected 63 entries from 1512 down to 24", rem_obs.size(),
               (rem_obs.size() > 0) ? rem_obs[0] : -1);
    end
    n = exp_q.size();
    bad = 0;
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      o = (obs_rd < obs_q.size()) ? obs_q[obs_rd] : '1;
      obs_rd++;
      if (o !== e) bad++;
    end
    checks++;
    if (bad != 0 || n != 63) begin errors++; $display("FAIL ovf_loads got %0d wrong of %0d expected 0 wrong of 63", bad, n); end
    checks++;
    if (frame_num !== 16'd5) begin errors++; $display("FAIL ovf_frame got %0d expected 5", frame_num); end
  endtask

  task automatic test_reset_midload();
    int t, r0, n;
    bit ok;
    load_t e, o;
    lat = 7;
    r0 = obs_q.size();
    send_frame(50);
    t = 0;
    while (new_set !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    control_ready_new_set = 1'b1;
    @(negedge clk);
    control_ready_new_set = 1'b0;
    repeat (2) @(negedge clk);
    reset_N = 1'b0;
    @(negedge clk);
    checks++;
    if ({load_set_req, load_set_idx, load_base_addr, num_of_sets, counter_of_remain_bboxes, start_pe,
         new_set, frame_num, done_frame, busy, overflow_err} !== '0) begin
      errors++;
      $display("FAIL rst_mid_async sets=%0d remain=%0d frame=%0d busy=%b ovf=%b expected all 0", num_of_sets,
               counter_of_remain_bboxes, frame_num, busy, overflow_err);
    end
    @(negedge clk);
    reset_N = 1'b1;
    @(negedge clk);
    checks++;
    if (obs_q.size() - r0 != 2 || obs_q[obs_q.size() - 1].idx !== 6'd1 || obs_q[obs_q.size() - 1].base !== 11'd24) begin
      errors++;
      $display("FAIL rst_mid_loads got %0d requests before reset expected 2 ending at idx 1 base 24", obs_q.size() - r0);
    end
    exp_q.delete();
    obs_rd = obs_q.size();
    checks++;
    if ({load_set_req, start_pe, new_set, busy, frame_num, overflow_err} !== '0) begin
      errors++;
      $display("FAIL rst_mid_release req=%b new_set=%b busy=%b frame=%0d expected all 0", load_set_req, new_set, busy, frame_num);
    end
    lat = 1;
    send_frame(30);
    @(negedge clk);
    checks++;
    if (num_of_sets !== 6'd2 || counter_of_remain_bboxes !== 11'd30) begin
      errors++;
      $display("FAIL n30_calc sets=%0d remain=%0d expected 2/30", num_of_sets, counter_of_remain_bboxes);
    end
    run_frame(2, 1'b0, 1'b0, ok);
    checks++;
    if (!ok || rem_obs.size() != 2 || rem_obs[1] != 6 || frame_num !== 16'd1) begin
      errors++;
      $display("FAIL n30_run ok=%b remain=%p frame=%0d expected 30,6 and frame 1", ok, rem_obs, frame_num);
    end
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      o = (obs_rd < obs_q.size()) ? obs_q[obs_rd] : '1;
      obs_rd++;
      checks++;
      if (o !== e) begin errors++; $display("FAIL n30_load%0d got idx=%0d base=%0d expected idx=%0d base=%0d", i, o.idx, o.base, e.idx, e.base); end
    end
  endtask

  task automatic test_frame_wrap();
    for (int i = 0; i < 2; i++) begin
      send_frame(0);
      repeat (3) @(negedge clk);
    end
    checks++;
    if (s_frame_num !== 2'd3 || frame_num !== 16'd3) begin
      errors++;
      $display("FAIL wrap_allones narrow=%0d wide=%0d expected 3/3", s_frame_num, frame_num);
    end
    send_frame(0);
    repeat (3) @(negedge clk);
    checks++;
    if (s_frame_num !== 2'd0 || frame_num !== 16'd4) begin
      errors++;
      $display("FAIL wrap_zero narrow=%0d wide=%0d expected 0/4", s_frame_num, frame_num);
    end
  endtask

  initial begin : main
    test_reset();
    test_n50();
    test_n24();
    test_n0();
    test_lat7();
    test_overflow();
    test_reset_midload();
    test_frame_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
